// File: rtl/vend_pkg.sv
// ----------------------------------------------------------------------------
// vend_pkg
//  Shared definitions for the vend credit accumulator, the downstream vend FSM
//  and their benches:
//   - coin_type encodings (2-bit code sampled with coin_valid)
//   - coin values in cents
//   - state encoding of the credit accumulator
// ----------------------------------------------------------------------------
package vend_pkg;

    typedef enum logic [1:0] {
        COIN_5C   = 2'b00,
        COIN_10C  = 2'b01,
        COIN_25C  = 2'b10,
        COIN_100C = 2'b11
    } coin_type_e;

    localparam int COIN_5C_CENTS   = 5;
    localparam int COIN_10C_CENTS  = 10;
    localparam int COIN_25C_CENTS  = 25;
    localparam int COIN_100C_CENTS = 100;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COLLECT   = 3'd1,
        ST_REQUEST   = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_PAYOUT    = 3'd5
    } acc_state_e;

endpackage

// File: rtl/vend_coin_decoder.sv
// ----------------------------------------------------------------------------
// vend_coin_decoder
//  Purely combinational mapping of a coin_type code to its value in cents.
//  Ports:
//   i_coin_type  [1:0]          coin code (see vend_pkg::coin_type_e)
//   o_coin_value [CREDIT_W-1:0] coin value in cents
// ----------------------------------------------------------------------------
module vend_coin_decoder
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic [1:0]          i_coin_type,
    output logic [CREDIT_W-1:0] o_coin_value
);

    always_comb begin
        o_coin_value = '0;
        case (coin_type_e'(i_coin_type))
            COIN_5C:   o_coin_value = CREDIT_W'(COIN_5C_CENTS);
            COIN_10C:  o_coin_value = CREDIT_W'(COIN_10C_CENTS);
            COIN_25C:  o_coin_value = CREDIT_W'(COIN_25C_CENTS);
            COIN_100C: o_coin_value = CREDIT_W'(COIN_100C_CENTS);
            default:   o_coin_value = '0;
        endcase
    end

endmodule

// File: rtl/vend_credit_accumulator.sv
// ----------------------------------------------------------------------------
// vend_credit_accumulator
//  Upstream stage of the vend FSM. Accumulates coin credit, issues a one-cycle
//  start request once credit reaches PRICE, follows the vend FSM through its
//  ACTIVE phase and then pays out change. Cancel before the request refunds
//  the whole credit. All outputs are registered.
//  Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   coin_valid   1-cycle coin strobe
//   coin_type    coin code, sampled with coin_valid
//   cancel       refund request (level)
//   vend_busy    vend FSM ACTIVE indication
//   start        1-cycle vend request (high only in REQUEST)
//   credit       accumulated credit in cents
//   coin_reject  1-cycle: last sampled coin was not accepted
//   change_valid 1-cycle: change_amt is valid
//   change_amt   change/refund in cents, 0 when change_valid=0
// ----------------------------------------------------------------------------
module vend_credit_accumulator
    import vend_pkg::*;
#(
    parameter int PRICE      = 65,
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 200
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                cancel,
    input  logic                vend_busy,
    output logic                start,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt
);

    // Constants sized to the one-bit-wider sum so compares never wrap.
    localparam logic [CREDIT_W:0]   L_MAX_SUM   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W:0]   L_PRICE_SUM = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] L_PRICE     = CREDIT_W'(PRICE);

    acc_state_e          r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_start;
    logic                r_coin_reject;
    logic                r_change_valid;
    logic [CREDIT_W-1:0] r_change_amt;

    acc_state_e          w_state_next;
    logic [CREDIT_W-1:0] w_credit_next;
    logic [CREDIT_W-1:0] w_coin_value;
    logic [CREDIT_W:0]   w_sum;
    logic                w_fits;
    logic                w_coin_accept;
    logic                w_payout_go;
    logic [CREDIT_W-1:0] w_payout_amt;

    vend_coin_decoder #(
        .CREDIT_W (CREDIT_W)
    ) u_coin_decoder (
        .i_coin_type  (coin_type),
        .o_coin_value (w_coin_value)
    );

    assign w_sum  = {1'b0, r_credit} + {1'b0, w_coin_value};
    assign w_fits = (w_sum <= L_MAX_SUM);

    always_comb begin
        w_state_next  = r_state;
        w_credit_next = r_credit;
        w_coin_accept = 1'b0;
        w_payout_go   = 1'b0;
        w_payout_amt  = '0;
        case (r_state)
            ST_IDLE, ST_COLLECT: begin
                // Cancel has priority over a same-cycle coin, which is then
                // rejected; in IDLE there is nothing to refund so cancel is moot.
                if (cancel && (r_state == ST_COLLECT)) begin
                    w_state_next  = ST_PAYOUT;
                    w_payout_go   = 1'b1;
                    w_payout_amt  = r_credit;
                    w_credit_next = '0;
                end else if (coin_valid && w_fits) begin
                    w_coin_accept = 1'b1;
                    w_credit_next = w_sum[CREDIT_W-1:0];
                    w_state_next  = (w_sum >= L_PRICE_SUM) ? ST_REQUEST : ST_COLLECT;
                end
            end
            ST_REQUEST: begin
                w_state_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (vend_busy) begin
                    w_state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!vend_busy) begin
                    w_state_next  = ST_PAYOUT;
                    w_payout_go   = 1'b1;
                    w_payout_amt  = r_credit - L_PRICE;
                    w_credit_next = '0;
                end
            end
            ST_PAYOUT: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next  = ST_IDLE;
                w_credit_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_credit       <= '0;
            r_start        <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_change_valid <= 1'b0;
            r_change_amt   <= '0;
        end else begin
            r_state        <= w_state_next;
            r_credit       <= w_credit_next;
            // Registered Moore decode: high exactly while in REQUEST.
            r_start        <= (w_state_next == ST_REQUEST);
            r_coin_reject  <= coin_valid && !w_coin_accept;
            r_change_valid <= w_payout_go;
            r_change_amt   <= w_payout_go ? w_payout_amt : '0;
        end
    end

    assign start        = r_start;
    assign credit       = r_credit;
    assign coin_reject  = r_coin_reject;
    assign change_valid = r_change_valid;
    assign change_amt   = r_change_amt;

endmodule
